// File: rtl/bit_pattern_detector.sv
// rtl/bit_pattern_detector.sv - serial bit pattern detector with edge pulses and saturating match counter
// Define PATDET_OVERLAP_EN to keep history after a match so overlapping occurrences are also reported.
module bit_pattern_detector #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  output logic             match,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int               FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  // The oldest history bit shifts out on every valid edge, so only PAT_W-1 bits are kept.
  logic [PAT_W-2:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic              r_prev;
  logic              r_match;
  logic              r_rise;
  logic              r_fall;
  logic [CNT_W-1:0]  r_cnt;

  logic [PAT_W-1:0]  w_window;
  logic              w_hit;
  logic              w_rise;
  logic              w_fall;
  logic [FILL_W-1:0] w_fill_nxt;

  assign w_window = {r_hist, din};
  assign w_hit    = din_valid && (w_window == PATTERN) && (r_fill >= FILL_ARM);
  assign w_rise   = din_valid && din && !r_prev;
  assign w_fall   = din_valid && !din && r_prev;

  always_comb begin
    w_fill_nxt = r_fill;
    if (din_valid) begin
      if (r_fill != FILL_MAX) begin
        w_fill_nxt = r_fill + FILL_W'(1);
      end
`ifndef PATDET_OVERLAP_EN
      // A match consumes its bits; the next match needs a full fresh window.
      if (w_hit) begin
        w_fill_nxt = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_prev  <= 1'b0;
      r_match <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_match <= w_hit;
      r_rise  <= w_rise;
      r_fall  <= w_fall;
      r_fill  <= w_fill_nxt;
      if (din_valid) begin
        r_hist <= w_window[PAT_W-2:0];
        r_prev <= din;
      end
      if (w_hit && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign match     = r_match;
  assign rise      = r_rise;
  assign fall      = r_fall;
  assign match_cnt = r_cnt;

endmodule

// File: tb/tb_bit_pattern_detector.sv
// tb/tb_bit_pattern_detector.sv - self-checking bench for bit_pattern_detector (default and CNT_W=2 instances)
// Follows PATDET_OVERLAP_EN the same way the design does.
module tb_bit_pattern_detector;

  localparam int         PAT_W   = 4;
  localparam logic [3:0] PATTERN = 4'b1011;
`ifdef PATDET_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       match,  rise,  fall;
  logic [7:0] match_cnt;
  logic       match2, rise2, fall2;
  logic [1:0] match_cnt2;

  always #5 clk = ~clk;

  bit_pattern_detector dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .match(match), .rise(rise), .fall(fall), .match_cnt(match_cnt)
  );

  bit_pattern_detector #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .match(match2), .rise(rise2), .fall(fall2), .match_cnt(match_cnt2)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model: the valid bits seen since reset (or since the last consumed match), newest at the back.
  bit q[$];
  bit m_prev;
  int m_cnt8, m_cnt2;
  bit nxt_match, nxt_rise, nxt_fall;
  int nxt_cnt8, nxt_cnt2;
  bit exp_match, exp_rise, exp_fall;
  int exp_cnt8, exp_cnt2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit v, input bit d);
    bit         hit;
    logic [3:0] pat;
    pat = PATTERN;
    nxt_match = 1'b0;
    nxt_rise  = 1'b0;
    nxt_fall  = 1'b0;
    if (r) begin
      q.delete();
      m_prev = 1'b0;
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else if (v) begin
      nxt_rise = d && !m_prev;
      nxt_fall = !d && m_prev;
      m_prev   = d;
      q.push_back(d);
      if (q.size() > PAT_W) void'(q.pop_front());
      if (q.size() == PAT_W) begin
        hit = 1'b1;
        for (int k = 0; k < PAT_W; k++) if (q[k] != pat[PAT_W-1-k]) hit = 1'b0;
        if (hit) begin
          nxt_match = 1'b1;
          m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
          m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
          if (!OVL) q.delete();
        end
      end
    end
    nxt_cnt8 = m_cnt8;
    nxt_cnt2 = m_cnt2;
  endtask

  task automatic step(input bit r, input bit v, input bit d);
    rst = r;
    din_valid = v;
    din = d;
    model(r, v, d);
    @(posedge clk);
    #1;
    exp_match = nxt_match;
    exp_rise  = nxt_rise;
    exp_fall  = nxt_fall;
    exp_cnt8  = nxt_cnt8;
    exp_cnt2  = nxt_cnt2;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("match",  match,      exp_match);
      chk("rise",   rise,       exp_rise);
      chk("fall",   fall,       exp_fall);
      chk("cnt",    match_cnt,  exp_cnt8);
      chk("match2", match2,     exp_match);
      chk("rise2",  rise2,      exp_rise);
      chk("fall2",  fall2,      exp_fall);
      chk("cnt2",   match_cnt2, exp_cnt2);
    end
  end

  initial begin
    logic [31:0] vec;
    logic [31:0] vmask;
    rst = 1'b1;
    din = 1'b0;
    din_valid = 1'b0;
    step(1, 0, 0);
    check_en = 1'b1;
    step(1, 1, 1);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_match", match, 0);
    chk("rst_rise", rise, 0);

    // 1,0,1,1,0,1,1
    step(0, 1, 1); chk("first_rise", rise, 1);
    step(0, 1, 0); chk("first_fall", fall, 1);
    step(0, 1, 1);
    step(0, 1, 1); chk("m4", match, 1);
    step(0, 1, 0);
    step(0, 1, 1);
    step(0, 1, 1); chk("m7", match, OVL ? 1 : 0);
    chk("cnt_seq", match_cnt, OVL ? 2 : 1);

    // Gap of non-valid cycles inside a sequence
    step(1, 0, 0);
    step(0, 1, 1); step(0, 1, 0); step(0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, i[0]);
      chk("gap_quiet", {match, rise, fall}, 0);
    end
    step(0, 1, 1); chk("gap_match", match, 1);

    // Reset mid-sequence, with a valid 1 presented during reset
    step(1, 0, 0);
    step(0, 1, 1); step(0, 1, 0); step(0, 1, 1);
    step(1, 1, 1); chk("rst_mid_cnt", match_cnt, 0);
    step(0, 1, 1); chk("post_rst_nomatch", match, 0); chk("post_rst_rise", rise, 1);
    step(0, 1, 0);
    step(0, 1, 1);
    step(0, 1, 1); chk("post_rst_match", match, 1);

    // 0,1,1,0 edge pulses
    step(1, 0, 0);
    step(0, 1, 0); chk("e1", {rise, fall}, 2'b00);
    step(0, 1, 1); chk("e2", {rise, fall}, 2'b10);
    step(0, 1, 1); chk("e3", {rise, fall}, 2'b00);
    step(0, 1, 0); chk("e4", {rise, fall}, 2'b01);

    // Counter saturation on the CNT_W=2 instance
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1); step(0, 1, 0); step(0, 1, 1); step(0, 1, 1);
      if (i == 2) chk("sat_3rd", match_cnt2, 3);
    end
    chk("sat_5th", match_cnt2, 3);
    chk("cnt_5", match_cnt, 5);

    // Mixed vector with valid gaps, compared cycle by cycle against the model
    vec   = 32'hB6D9_5ACB;
    vmask = 32'hF7EF_BDFF;
    step(1, 0, 0);
    for (int i = 31; i >= 0; i--) step(0, vmask[i], vec[i]);
    step(0, 0, 0);

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_pattern_detector.md
BIT_PATTERN_DETECTOR -- requirements
Module: bit_pattern_detector

Interface
REQ-001 Parameter PAT_W, default 4, pattern length in bits (legal range 2..16).
REQ-002 Parameter PATTERN, default 4'b1011, target sequence; MSB is the oldest bit.
REQ-003 Parameter CNT_W, default 8, width of the match counter.
REQ-004 Port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-005 Port rst, input, 1, synchronous active-high reset.
REQ-006 Port din, input, 1, serial bit from the upstream D flip-flop q output.
REQ-007 Port din_valid, input, 1, qualifies din on the current posedge.
REQ-008 Port match, output, 1, registered one-cycle pulse on pattern detection.
REQ-009 Port rise, output, 1, registered one-cycle pulse on a 0->1 transition between consecutive valid bits.
REQ-010 Port fall, output, 1, registered one-cycle pulse on a 1->0 transition between consecutive valid bits.
REQ-011 Port match_cnt, output, CNT_W, saturating count of matches since reset.

Function
REQ-012 A posedge with din_valid=1 shifts din into a PAT_W-bit history register at the LSB.
REQ-013 A posedge with din_valid=0 holds history, fill count and previous bit; match, rise and fall are 0 on the following cycle.
REQ-014 The fill counter counts valid bits accepted, saturates at PAT_W, and is cleared by reset.
REQ-015 match is 1 in the cycle after a valid edge only when {history[PAT_W-2:0], din} equals PATTERN and the fill count before that edge is at least PAT_W-1.
REQ-016 Latency from the capturing edge to the match, rise or fall pulse is exactly one clock.
REQ-017 rise is 1 in the cycle after a valid edge with din=1 and stored previous bit 0; fall is the complement case (din=0, previous bit 1).
REQ-018 The stored previous bit updates only on valid edges.
REQ-019 match_cnt increments by 1 on every match pulse and holds at 2^CNT_W-1 without wrapping.
REQ-020 match, rise or fall may assert together in the same cycle.
REQ-021 Non-valid cycles between valid bits do not break a sequence; only valid bits form the stream.

Reset
REQ-022 rst=1 on a posedge clears history, fill count and previous bit to 0, and forces match, rise, fall and match_cnt to 0 in the next cycle.
REQ-023 rst takes priority over din_valid; a bit presented during reset is discarded.
REQ-024 Reset mid-sequence discards partial history; a full PAT_W valid bits are required after reset before any match.
REQ-025 After reset the previous bit is 0, so a first valid din=1 produces a rise pulse.

Configuration
REQ-026 Macro PATDET_OVERLAP_EN selects overlap handling.
REQ-027 With PATDET_OVERLAP_EN defined, history and fill count are kept after a match, so overlapping matches are detected.
REQ-028 Without PATDET_OVERLAP_EN, the valid edge that produces a match also clears the fill count to 0, so the next match needs PAT_W fresh bits.
REQ-029 Without PATDET_OVERLAP_EN, the matching bit still updates the previous bit used for rise and fall.

Verification
REQ-030 Defaults with PATDET_OVERLAP_EN, valid stream 1,0,1,1,0,1,1 -> match pulses after the 4th and 7th bits; match_cnt=2.
REQ-031 Same stream without PATDET_OVERLAP_EN -> a single match after the 4th bit; match_cnt=1.
REQ-032 Stream 1,0,1 then din_valid=0 for 3 cycles then 1 -> match one cycle after the final valid bit; no pulses during the gap.
REQ-033 Stream 1,0,1, then rst for 1 cycle, then 1 -> no match; the next match needs 1,0,1,1 after reset.
REQ-034 Valid stream 0,1,1,0 after reset -> rise after bit 2 and fall after bit 4; no pulse after bits 1 and 3.
REQ-035 CNT_W=2 with 5 matches -> match_cnt reads 3 after the 3rd match and stays 3.
